// File: rtl/byte_serializer.sv
// Byte FIFO plus serializer driving a deserializer's data/write-strobe pair, MSB first by default.
// Define BYTE_SERIALIZER_LSB_FIRST_EN to send each byte LSB first instead.
module byte_serializer #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock_1M,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       enq_in,
  input  logic       ready_in,
  output logic       data_out,
  output logic       write_out,
  output logic [3:0] len_out,
  output logic       status_out,
  output logic       busy_out
);

  localparam int         PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_L  = 4'(DEPTH);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    len_q, len_d;
  logic          enq_prev_q;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic          data_out_q, data_out_d;
  logic          write_out_q, write_out_d;
  logic          enq_edge, pop, push, start;

  // A pop in LOAD frees a slot in the same cycle, so a full FIFO still accepts that enqueue.
  always_comb begin
    enq_edge = enq_in & ~enq_prev_q;
    pop      = (state_q == LOAD);
    push     = enq_edge & ((len_q != DEPTH_L) | pop);
    start    = (len_q != 4'd0) & ready_in;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    len_d    = len_q;
    if (push && !pop) begin
      len_d = len_q + 4'd1;
    end else if (pop && !push) begin
      len_d = len_q - 4'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        shreg_d   = mem_q[rd_ptr_q];
        bit_cnt_d = 3'd0;
        state_d   = SHIFT;
      end
      SHIFT: begin
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
        shreg_d = {1'b0, shreg_q[7:1]};
`else
        shreg_d = {shreg_q[6:0], 1'b0};
`endif
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          gap_cnt_d = 4'd0;
          state_d   = GAP;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        // The idle decision is taken on the last gap cycle so back-to-back bytes keep an 8+GAP+1 period.
        if (gap_cnt_q == GAP_LAST) begin
          state_d = start ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    write_out_d = (state_d == SHIFT);
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
    data_out_d  = write_out_d & shreg_d[0];
`else
    data_out_d  = write_out_d & shreg_d[7];
`endif
  end

  always_ff @(posedge clock_1M or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= 4'd0;
      enq_prev_q  <= 1'b0;
      shreg_q     <= 8'd0;
      bit_cnt_q   <= 3'd0;
      gap_cnt_q   <= 4'd0;
      data_out_q  <= 1'b0;
      write_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      enq_prev_q  <= enq_in;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_out_q  <= data_out_d;
      write_out_q <= write_out_d;
    end
  end

  always_ff @(posedge clock_1M) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign write_out  = write_out_q;
  assign len_out    = len_q;
  assign status_out = (len_q == DEPTH_L);
  assign busy_out   = (state_q != IDLE);

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: a byte-queue/timeline model checked every cycle plus literal checks.
`timescale 1ns/1ps
module tb_byte_serializer;

  localparam int DEPTH  = 8;
  localparam int GAP    = 2;
  localparam int PERIOD = 1 + 8 + GAP;

  // Bytes as they are reassembled from the line, first bit in the MSB position.
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
  localparam logic [7:0] SER_AA = 8'h55;
  localparam logic [7:0] SER_55 = 8'hAA;
  localparam logic [7:0] SER_CC = 8'h33;
  localparam logic [7:0] SER_33 = 8'hCC;
`else
  localparam logic [7:0] SER_AA = 8'hAA;
  localparam logic [7:0] SER_55 = 8'h55;
  localparam logic [7:0] SER_CC = 8'hCC;
  localparam logic [7:0] SER_33 = 8'h33;
`endif

  logic       clock_1M = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] data_in  = 8'd0;
  logic       enq_in   = 1'b0;
  logic       ready_in = 1'b0;
  logic       data_out, write_out, status_out, busy_out;
  logic [3:0] len_out;

  int checks = 0;
  int errors = 0;
  logic checkEn = 1'b0;

  byte_serializer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clock_1M  (clock_1M),
    .reset     (reset),
    .data_in   (data_in),
    .enq_in    (enq_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .write_out (write_out),
    .len_out   (len_out),
    .status_out(status_out),
    .busy_out  (busy_out)
  );

  always #500 clock_1M = ~clock_1M;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a byte queue plus the position inside the current byte slot (-1 = idle, 0 = load, 1..8 = bits, then gap).
  logic [7:0] mq[$];
  logic [7:0] cur;
  int         pos;
  logic       prevEnq;
  logic       mEdge, mPop;
  int         lenPre;

  always @(posedge clock_1M or negedge reset) begin
    if (!reset) begin
      mq.delete();
      cur     = 8'd0;
      pos     = -1;
      prevEnq = 1'b0;
    end else begin
      mEdge   = enq_in && !prevEnq;
      prevEnq = enq_in;
      lenPre  = mq.size();
      mPop    = (pos == 0);
      if (mPop) cur = mq.pop_front();
      if (mEdge && (lenPre < DEPTH || mPop)) mq.push_back(data_in);
      if (pos >= 0 && pos < PERIOD - 1) pos = pos + 1;
      else pos = (lenPre > 0 && ready_in) ? 0 : -1;
    end
  end

  logic       expWrite, expData;
  logic [2:0] bitIdx;

  always @(negedge clock_1M) begin
    if (checkEn) begin
      expWrite = (pos >= 1 && pos <= 8);
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
      bitIdx = 3'(pos - 1);
`else
      bitIdx = 3'(8 - pos);
`endif
      expData = expWrite ? cur[bitIdx] : 1'b0;
      checkOutput("write_out", int'(write_out), int'(expWrite));
      checkOutput("data_out", int'(data_out), int'(expData));
      checkOutput("len_out", int'(len_out), mq.size());
      checkOutput("status_out", int'(status_out), int'(mq.size() == DEPTH));
      checkOutput("busy_out", int'(busy_out), int'(pos >= 0));
    end
  end

  // Reassemble bursts from the line and note the cycle each burst started.
  logic [7:0] got[$];
  int         startQ[$];
  logic [7:0] cap = 8'd0;
  int         capCnt = 0;
  int         cycNeg = 0;
  int         burstStart = 0;
  logic       prevW = 1'b0;

  always @(negedge clock_1M) begin
    cycNeg++;
    if (!reset) begin
      capCnt = 0;
      prevW  = 1'b0;
    end else begin
      if (write_out && !prevW) burstStart = cycNeg;
      prevW = write_out;
      if (write_out) begin
        cap = {cap[6:0], data_out};
        capCnt++;
        if (capCnt == 8) begin
          got.push_back(cap);
          startQ.push_back(burstStart);
          capCnt = 0;
        end
      end
    end
  end

  int edgeNeg = 0;

  task automatic applyStimulus(input logic [7:0] d);
    @(posedge clock_1M); #1;
    data_in = d;
    enq_in  = 1'b1;
    @(posedge clock_1M);
    @(negedge clock_1M); #1;
    edgeNeg = cycNeg;
    enq_in  = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clock_1M);
      if (!busy_out && len_out == 4'd0 && !write_out) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitIdle: still busy after %0d cycles, required idle", limit);
    end
    #1;
  endtask

  logic [7:0] fillBytes [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h3C, 8'h66, 8'hA5, 8'hDB};

  initial begin
    repeat (3) @(posedge clock_1M);
    #1;
    checkOutput("rst write_out", int'(write_out), 0);
    checkOutput("rst data_out", int'(data_out), 0);
    checkOutput("rst len_out", int'(len_out), 0);
    checkOutput("rst status_out", int'(status_out), 0);
    checkOutput("rst busy_out", int'(busy_out), 0);
    reset   = 1'b1;
    checkEn = 1'b1;

    $display("[TB] single byte 0xAA");
    ready_in = 1'b1;
    applyStimulus(8'hAA);
    waitIdle(60);
    checkOutput("t1 bursts", got.size(), 1);
    if (got.size() == 1) begin
      checkOutput("t1 byte", int'(got[0]), int'(SER_AA));
      checkOutput("t1 latency", startQ[0] - edgeNeg, 2);
    end

    $display("[TB] three bytes queued while not ready");
    got.delete(); startQ.delete();
    ready_in = 1'b0;
    applyStimulus(8'h55);
    applyStimulus(8'hCC);
    applyStimulus(8'h33);
    checkOutput("t2 len", int'(len_out), 3);
    @(posedge clock_1M); #1;
    ready_in = 1'b1;
    waitIdle(100);
    checkOutput("t2 bursts", got.size(), 3);
    if (got.size() == 3) begin
      checkOutput("t2 byte0", int'(got[0]), int'(SER_55));
      checkOutput("t2 byte1", int'(got[1]), int'(SER_CC));
      checkOutput("t2 byte2", int'(got[2]), int'(SER_33));
      checkOutput("t2 period01", startQ[1] - startQ[0], 11);
      checkOutput("t2 period12", startQ[2] - startQ[1], 11);
    end

    $display("[TB] fill, overflow drop, enqueue during load while full");
    got.delete(); startQ.delete();
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(fillBytes[i]);
    checkOutput("t3 full", int'(status_out), 1);
    checkOutput("t3 len8", int'(len_out), 8);
    applyStimulus(8'hFF);
    checkOutput("t3 drop len", int'(len_out), 8);
    @(posedge clock_1M); #1;
    ready_in = 1'b1;
    @(posedge clock_1M); #1;
    data_in = 8'h99;
    enq_in  = 1'b1;
    @(posedge clock_1M); #1;
    enq_in  = 1'b0;
    checkOutput("t3 load+enq len", int'(len_out), 8);
    waitIdle(200);
    checkOutput("t3 bursts", got.size(), 9);
    if (got.size() == 9) begin
      for (int i = 0; i < 8; i++) checkOutput("t3 byte", int'(got[i]), int'(fillBytes[i]));
      checkOutput("t3 last", int'(got[8]), 8'h99);
    end

    $display("[TB] enq held high");
    got.delete(); startQ.delete();
    ready_in = 1'b0;
    @(posedge clock_1M); #1;
    data_in = 8'h33;
    enq_in  = 1'b1;
    repeat (100) @(posedge clock_1M);
    #1;
    enq_in = 1'b0;
    checkOutput("t4 len", int'(len_out), 1);
    ready_in = 1'b1;
    waitIdle(60);
    checkOutput("t4 bursts", got.size(), 1);

    $display("[TB] reset mid-byte");
    got.delete(); startQ.delete();
    ready_in = 1'b0;
    applyStimulus(8'h5A);
    applyStimulus(8'h0F);
    @(posedge clock_1M); #1;
    ready_in = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clock_1M);
        if (write_out) seen = 1'b1;
      end
      checkOutput("t5 burst began", int'(seen), 1);
    end
    repeat (3) @(posedge clock_1M);
    #200;
    checkOutput("t5 pre len", int'(len_out), 1);
    checkOutput("t5 pre write", int'(write_out), 1);
    reset = 1'b0;
    #1;
    checkOutput("t5 write_out", int'(write_out), 0);
    checkOutput("t5 data_out", int'(data_out), 0);
    checkOutput("t5 len_out", int'(len_out), 0);
    checkOutput("t5 busy_out", int'(busy_out), 0);
    repeat (2) @(posedge clock_1M);
    #1;
    reset = 1'b1;
    got.delete(); startQ.delete();
    applyStimulus(8'hC3);
    waitIdle(60);
    checkOutput("t5 bursts", got.size(), 1);
    if (got.size() == 1) checkOutput("t5 byte", int'(got[0]), 8'hC3);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
